// File: rtl/id_ex_pkg.sv
// Shared types for the ID->EX boundary: ALU select, memory op and op-class encodings.
package id_ex_pkg;

    typedef enum logic [1:0] {
        ALU_NOP   = 2'd0,
        ALU_LOGIC = 2'd1,
        ALU_SHIFT = 2'd2,
        ALU_ARITH = 2'd3
    } alusel_t;

    typedef enum logic [1:0] {
        MEM_NOP       = 2'd0,
        MEM_WRITE_REG = 2'd1,
        MEM_LOAD      = 2'd2,
        MEM_STORE     = 2'd3
    } memop_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_LOGIC = 3'd1,
        CLS_SHIFT = 3'd2,
        CLS_ARITH = 3'd3,
        CLS_LOAD  = 3'd4,
        CLS_STORE = 3'd5,
        CLS_RSV6  = 3'd6,
        CLS_RSV7  = 3'd7
    } op_class_t;

    localparam int REG_ZERO    = 0;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/ex_class_decode.sv
// Op class -> {alusel, memop, writeEnable}; shared with the hazard unit.
module ex_class_decode
    import id_ex_pkg::*;
(
    input  op_class_t cls_i,
    output alusel_t   alusel_o,
    output memop_t    memop_o,
    output logic      we_o
);

    always_comb begin
        alusel_o = ALU_NOP;
        memop_o  = MEM_NOP;
        we_o     = 1'b0;
        unique case (cls_i)
            CLS_LOGIC: begin
                alusel_o = ALU_LOGIC;
                memop_o  = MEM_WRITE_REG;
                we_o     = 1'b1;
            end
            CLS_SHIFT: begin
                alusel_o = ALU_SHIFT;
                memop_o  = MEM_WRITE_REG;
                we_o     = 1'b1;
            end
            CLS_ARITH: begin
                alusel_o = ALU_ARITH;
                memop_o  = MEM_WRITE_REG;
                we_o     = 1'b1;
            end
            CLS_LOAD: begin
                alusel_o = ALU_ARITH;
                memop_o  = MEM_LOAD;
                we_o     = 1'b1;
            end
            CLS_STORE: begin
                alusel_o = ALU_ARITH;
                memop_o  = MEM_STORE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready flow control, flush and stall hold.
// Optional stall counter enabled by ID_EX_STALL_CNT_EN.
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFFSET_W   = 16,
    parameter int EX_OP_W    = 8,
    parameter int CLASS_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         id_valid,
    output logic                         id_ready,
    input  logic [EX_OP_W-1:0]           id_exop,
    input  logic [WORD_W-1:0]            id_srcLeft,
    input  logic [WORD_W-1:0]            id_srcRight,
    input  logic [OFFSET_W-1:0]          id_offset,
    input  logic [REG_ADDR_W-1:0]        id_dest,
    input  logic                         ex_ready,
    output logic                         ex_valid,
    output logic [1:0]                   ex_alusel,
    output logic [EX_OP_W-CLASS_W-1:0]   ex_aluop,
    output logic [WORD_W-1:0]            ex_srcLeft,
    output logic [WORD_W-1:0]            ex_srcRight,
    output logic [WORD_W-1:0]            ex_offset,
    output logic [1:0]                   ex_memop,
    output logic [REG_ADDR_W-1:0]        ex_dest,
    output logic                         ex_writeEnable,
    output logic [STALL_CNT_W-1:0]       stall_cycles
);

    localparam int ALUOP_W = EX_OP_W - CLASS_W;

    logic                  accept;
    op_class_t             cls;
    alusel_t               dec_alusel;
    memop_t                dec_memop;
    logic                  dec_we;

    logic                  valid_q, valid_d;
    alusel_t               alusel_q, alusel_d;
    memop_t                memop_q, memop_d;
    logic                  we_q, we_d;
    logic [ALUOP_W-1:0]    aluop_q, aluop_d;
    logic [WORD_W-1:0]     left_q, left_d;
    logic [WORD_W-1:0]     right_q, right_d;
    logic [WORD_W-1:0]     off_q, off_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;

    assign id_ready = !valid_q | ex_ready;
    assign accept   = id_valid & id_ready & !flush;
    assign cls      = op_class_t'(id_exop[EX_OP_W-1 -: CLASS_W]);

    ex_class_decode u_dec (
        .cls_i    (cls),
        .alusel_o (dec_alusel),
        .memop_o  (dec_memop),
        .we_o     (dec_we)
    );

    always_comb begin
        valid_d  = valid_q;
        alusel_d = alusel_q;
        memop_d  = memop_q;
        we_d     = we_q;
        aluop_d  = aluop_q;
        left_d   = left_q;
        right_d  = right_q;
        off_d    = off_q;
        dest_d   = dest_q;
        if (flush) begin
            valid_d  = 1'b0;
            alusel_d = ALU_NOP;
            memop_d  = MEM_NOP;
            we_d     = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            alusel_d = dec_alusel;
            memop_d  = dec_memop;
            // r0 is hardwired; memop still travels for store/load paths
            we_d     = dec_we & (id_dest != REG_ADDR_W'(REG_ZERO));
            aluop_d  = id_exop[ALUOP_W-1:0];
            left_d   = id_srcLeft;
            right_d  = id_srcRight;
            off_d    = WORD_W'($signed(id_offset));
            dest_d   = id_dest;
        end else if (valid_q & ex_ready) begin
            valid_d  = 1'b0;
            alusel_d = ALU_NOP;
            memop_d  = MEM_NOP;
            we_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            alusel_q <= ALU_NOP;
            memop_q  <= MEM_NOP;
            we_q     <= 1'b0;
            aluop_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            off_q    <= '0;
            dest_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            alusel_q <= alusel_d;
            memop_q  <= memop_d;
            we_q     <= we_d;
            aluop_q  <= aluop_d;
            left_q   <= left_d;
            right_q  <= right_d;
            off_q    <= off_d;
            dest_q   <= dest_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !ex_ready && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign ex_valid       = valid_q;
    assign ex_alusel      = alusel_q;
    assign ex_memop       = memop_q;
    assign ex_writeEnable = we_q;
    assign ex_aluop       = aluop_q;
    assign ex_srcLeft     = left_q;
    assign ex_srcRight    = right_q;
    assign ex_offset      = off_q;
    assign ex_dest        = dest_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed ops pushed as expectations,
// monitor pops on every EX transfer.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [1:0]  alusel;
        logic [4:0]  aluop;
        logic [1:0]  memop;
        logic        we;
        logic [31:0] left;
        logic [31:0] right;
        logic [31:0] off;
        logic [4:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_exop;
    logic [31:0] id_srcLeft;
    logic [31:0] id_srcRight;
    logic [15:0] id_offset;
    logic [4:0]  id_dest;
    logic        ex_ready;
    logic        ex_valid;
    logic [1:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcLeft;
    logic [31:0] ex_srcRight;
    logic [31:0] ex_offset;
    logic [1:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic [15:0] stall_cycles;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t exp_c;
    exp_t zero_e;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_exop        (id_exop),
        .id_srcLeft     (id_srcLeft),
        .id_srcRight    (id_srcRight),
        .id_offset      (id_offset),
        .id_dest        (id_dest),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_alusel      (ex_alusel),
        .ex_aluop       (ex_aluop),
        .ex_srcLeft     (ex_srcLeft),
        .ex_srcRight    (ex_srcRight),
        .ex_offset      (ex_offset),
        .ex_memop       (ex_memop),
        .ex_dest        (ex_dest),
        .ex_writeEnable (ex_writeEnable),
        .stall_cycles   (stall_cycles)
    );

    function automatic exp_t actual();
        return '{ex_alusel, ex_aluop, ex_memop, ex_writeEnable,
                 ex_srcLeft, ex_srcRight, ex_offset, ex_dest};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_e(input string name, input exp_t act, input exp_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [15:0] off, input logic [4:0] dest,
                         input logic [1:0] a_e, input logic [1:0] m_e, input logic we_e,
                         input logic [31:0] off_e, input bit push);
        id_exop     = op;
        id_srcLeft  = l;
        id_srcRight = r;
        id_offset   = off;
        id_dest     = dest;
        id_valid    = 1'b1;
        if (push) sb_q.push_back('{a_e, op[4:0], m_e, we_e, l, r, off_e, dest});
        step();
        id_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_transfer: got %h expected none", actual());
            end else begin
                chk_e("transfer", actual(), sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_stall;
        zero_e      = '0;
        rst         = 1'b1;
        flush       = 1'b0;
        id_valid    = 1'b1;
        id_exop     = 8'h23;
        id_srcLeft  = 32'hDEAD_BEEF;
        id_srcRight = 32'h1234_5678;
        id_offset   = 16'hFFFF;
        id_dest     = 5'd5;
        ex_ready    = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk_e("rst_fields", actual(), zero_e);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        rst      = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("rst_id_ready", 32'(id_ready), 32'd1);

        // LOGIC aluop 3, then back-to-back LOAD with positive/negative offsets
        issue(8'h23, 32'h0000_0011, 32'h0000_0022, 16'h0010, 5'd5,
              2'd1, 2'd1, 1'b1, 32'h0000_0010, 1'b1);
        chk("logic_valid", 32'(ex_valid), 32'd1);
        issue(8'h80, 32'h0000_1000, 32'h0, 16'hFFFC, 5'd7,
              2'd3, 2'd2, 1'b1, 32'hFFFF_FFFC, 1'b1);
        issue(8'h80, 32'h0000_2000, 32'h0, 16'hFFFC, 5'd0,
              2'd3, 2'd2, 1'b0, 32'hFFFF_FFFC, 1'b1);
        issue(8'h80, 32'h0000_3000, 32'h0, 16'h7FFF, 5'd8,
              2'd3, 2'd2, 1'b1, 32'h0000_7FFF, 1'b1);
        issue(8'h80, 32'h0000_4000, 32'h0, 16'h8000, 5'd9,
              2'd3, 2'd2, 1'b1, 32'hFFFF_8000, 1'b1);
        step();
        chk("drain_valid", 32'(ex_valid), 32'd0);

        // stall hold for 3 cycles
        ex_ready = 1'b0;
        exp_c = '{2'd3, 5'd1, 2'd1, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 32'h0000_0004, 5'd9};
        issue(8'h61, 32'hAAAA_0001, 32'h5555_0002, 16'h0004, 5'd9,
              2'd3, 2'd1, 1'b1, 32'h0000_0004, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", 32'(ex_valid), 32'd1);
            chk("hold_id_ready", 32'(id_ready), 32'd0);
            chk_e("hold_fields", actual(), exp_c);
        end
`ifdef ID_EX_STALL_CNT_EN
        exp_stall = 3;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", 32'(stall_cycles), 32'(exp_stall));
        ex_ready = 1'b1;
        step();
        chk("post_hold_valid", 32'(ex_valid), 32'd0);

        // flush kills held op and drops incoming op
        ex_ready = 1'b0;
        issue(8'h23, 32'hBAD0_0001, 32'hBAD0_0002, 16'h0001, 5'd3,
              2'd1, 2'd1, 1'b1, 32'h1, 1'b0);
        id_exop     = 8'h41;
        id_srcLeft  = 32'hBAD0_0003;
        id_dest     = 5'd4;
        id_valid    = 1'b1;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        id_valid = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_memop", 32'(ex_memop), 32'd0);
        chk("flush_we", 32'(ex_writeEnable), 32'd0);
        chk("flush_alusel", 32'(ex_alusel), 32'd0);
        ex_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_ghost", 32'(ex_valid), 32'd0);

        // 4-op stream, no bubbles, ending with reserved class 7
        issue(8'h25, 32'h0000_0101, 32'h0000_0202, 16'h0003, 5'd1,
              2'd1, 2'd1, 1'b1, 32'h0000_0003, 1'b1);
        chk("stream0_valid", 32'(ex_valid), 32'd1);
        issue(8'h42, 32'h0000_0303, 32'h0000_0404, 16'h0005, 5'd2,
              2'd2, 2'd1, 1'b1, 32'h0000_0005, 1'b1);
        chk("stream1_valid", 32'(ex_valid), 32'd1);
        issue(8'hA7, 32'h0000_0505, 32'h0000_0606, 16'hFFF0, 5'd4,
              2'd3, 2'd3, 1'b0, 32'hFFFF_FFF0, 1'b1);
        chk("stream2_valid", 32'(ex_valid), 32'd1);
        issue(8'hE9, 32'h0000_0707, 32'h0000_0808, 16'h0000, 5'd6,
              2'd0, 2'd0, 1'b0, 32'h0000_0000, 1'b1);
        chk("stream3_valid", 32'(ex_valid), 32'd1);
        step();
        chk("stream_end_valid", 32'(ex_valid), 32'd0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
